cpu_control_sequencer: RTL and testbench
========================================

Name: cpu_control_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 4-bit CPU; sits directly upstream of the datapath registers (accumulator A, register B, output register).
- Holds the program counter and the instruction register, and decodes 8-bit instructions (opcode[7:4], immediate[3:0]).
- Drives one-cycle write-enable pulses, ALU op select and the immediate operand into the datapath.

Parameters:
- PC_WIDTH, 4, program-counter width; program memory depth is 2**PC_WIDTH instructions.
- DATA_WIDTH, 4, datapath/immediate width; must equal the register width used downstream.

Ports:
- clk_i  input  1  single clock, all state updates on rising edge
- reset_i  input  1  synchronous, active-high reset
- run_i  input  1  level start/continue; sampled only in IDLE and FETCH
- instr_i  input  8  instruction word from program memory at address pc_o; valid combinationally same cycle
- acc_zero_i  input  1  high when accumulator value == 0; sampled in EXECUTE
- pc_o  output  PC_WIDTH  program-memory address
- imm_o  output  DATA_WIDTH  immediate field IR[3:0]
- alu_op_o  output  3  ALU select: 0 PASS_IMM, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 PASS_A
- acc_we_o  output  1  accumulator write enable pulse
- regb_we_o  output  1  register-B write enable pulse
- out_we_o  output  1  output-register write enable pulse
- halted_o  output  1  high while in HALT

Behaviour:
- Reset (synchronous, reset_i high at a clock edge): state=IDLE, pc_o=0, IR=0x00, imm_o=0, alu_op_o=0, all *_we_o=0, halted_o=0. Reset has priority over everything, including mid-instruction; no write-enable pulse may occur in the cycle after a reset edge.
- States: IDLE, FETCH, DECODE, EXECUTE, HALT.
- IDLE: run_i=1 -> FETCH; otherwise stay.
- FETCH: if run_i=0 -> IDLE with PC unchanged. Otherwise IR<=instr_i -> DECODE.
- DECODE: alu_op_o and imm_o become valid from IR -> EXECUTE.
- EXECUTE: exactly one cycle; write enables are asserted combinationally in this state only, so each pulse is exactly 1 cycle wide. Next state is FETCH, or HALT for HLT. Every instruction therefore takes 3 cycles.
- PC update at the end of EXECUTE: pc<=pc+1 (modulo 2**PC_WIDTH, so 0xF wraps to 0x0), except a taken jump, where pc<=imm (zero-extended/truncated to PC_WIDTH).
- Opcodes (opcode -> operation):
  - 0x0 NOP -> no enables.
  - 0x1 LDI -> alu PASS_IMM, acc_we.
  - 0x2 ADD, 0x3 SUB, 0x4 AND, 0x5 OR, 0x6 XOR -> A op B into A, acc_we.
  - 0x7 MOVB -> alu PASS_A, regb_we.
  - 0x8 OUT -> alu PASS_A, out_we.
  - 0x9 JMP -> pc<=imm unconditionally.
  - 0xA JZ -> pc<=imm iff acc_zero_i=1 in EXECUTE.
  - 0xF HLT -> HALT.
  - 0xB-0xE -> treated as NOP.
- alu_op_o holds its last value outside EXECUTE; consumers ignore it unless a write enable is high.
- HALT: halted_o=1, no enables, PC frozen at the address after HLT (pc+1). Left only by reset; run_i is ignored.
- Arithmetic overflow/borrow is the ALU's concern; the sequencer carries no flags other than acc_zero_i.
- run_i dropping in DECODE/EXECUTE does not abort; the current instruction completes, then FETCH sees run_i=0 -> IDLE.

Decomposition:
- Shared package cpu_pkg: opcode constants, ALU op encoding (3-bit), sequencer state encoding, INSTR_WIDTH=8.
- One natural sub-module: cpu_program_counter (increment with wrap, load for jumps, synchronous reset).
- Write-enable outputs drive the existing register block's write_en_i directly.

Test Plan:
- Reset then run_i=1; program LDI 5, OUT -> acc_we pulse at cycle 3 with imm_o=5/alu_op=0; out_we pulse at cycle 6 with alu_op=6; pc_o sequence 0,0,0,1,1,1,2.
- Program LDI 0; JZ 4; LDI 1; with acc_zero_i=1 during JZ EXECUTE -> pc_o becomes 4. Repeat with acc_zero_i=0 -> pc_o becomes 2.
- Program memory filled with NOP, run for 16 instructions -> pc_o wraps 0xF->0x0, no enables ever asserted.
- HLT at address 3 -> halted_o=1 from cycle after EXECUTE, pc_o=4 frozen for 20 cycles, run_i toggling has no effect; reset_i=1 -> halted_o=0, pc_o=0, state IDLE.
- Assert reset_i during EXECUTE of ADD -> acc_we low in every cycle after the reset edge, all outputs at reset values.
- run_i=0 in FETCH after MOVB completes -> regb_we pulsed once, then IDLE with pc_o held at 1; run_i=1 resumes fetching from address 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the 4-bit CPU: opcodes, ALU selects, sequencer states and the opcode decode table.
// Pure definitions; no timing or flow control lives here.
package cpu_pkg;

   localparam int INSTR_WIDTH = 8;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_MOVB = 4'h7;
   localparam logic [3:0] OP_OUT  = 4'h8;
   localparam logic [3:0] OP_JMP  = 4'h9;
   localparam logic [3:0] OP_JZ   = 4'hA;
   localparam logic [3:0] OP_HLT  = 4'hF;

   localparam logic [2:0] ALU_PASS_IMM = 3'd0;
   localparam logic [2:0] ALU_ADD      = 3'd1;
   localparam logic [2:0] ALU_SUB      = 3'd2;
   localparam logic [2:0] ALU_AND      = 3'd3;
   localparam logic [2:0] ALU_OR       = 3'd4;
   localparam logic [2:0] ALU_XOR      = 3'd5;
   localparam logic [2:0] ALU_PASS_A   = 3'd6;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_FETCH   = 3'd1;
   localparam logic [2:0] ST_DECODE  = 3'd2;
   localparam logic [2:0] ST_EXECUTE = 3'd3;
   localparam logic [2:0] ST_HALT    = 3'd4;

   typedef struct packed {
      logic       acc_we;
      logic       regb_we;
      logic       out_we;
      logic       uses_alu;
      logic [2:0] alu_op;
   } dec_t;

   function automatic dec_t decode_op(input logic [3:0] op);
      dec_t d;
      d = '0;
      case (op)
         OP_LDI:  d = '{acc_we: 1'b1, regb_we: 1'b0, out_we: 1'b0, uses_alu: 1'b1, alu_op: ALU_PASS_IMM};
         OP_ADD:  d = '{acc_we: 1'b1, regb_we: 1'b0, out_we: 1'b0, uses_alu: 1'b1, alu_op: ALU_ADD};
         OP_SUB:  d = '{acc_we: 1'b1, regb_we: 1'b0, out_we: 1'b0, uses_alu: 1'b1, alu_op: ALU_SUB};
         OP_AND:  d = '{acc_we: 1'b1, regb_we: 1'b0, out_we: 1'b0, uses_alu: 1'b1, alu_op: ALU_AND};
         OP_OR:   d = '{acc_we: 1'b1, regb_we: 1'b0, out_we: 1'b0, uses_alu: 1'b1, alu_op: ALU_OR};
         OP_XOR:  d = '{acc_we: 1'b1, regb_we: 1'b0, out_we: 1'b0, uses_alu: 1'b1, alu_op: ALU_XOR};
         OP_MOVB: d = '{acc_we: 1'b0, regb_we: 1'b1, out_we: 1'b0, uses_alu: 1'b1, alu_op: ALU_PASS_A};
         OP_OUT:  d = '{acc_we: 1'b0, regb_we: 1'b0, out_we: 1'b1, uses_alu: 1'b1, alu_op: ALU_PASS_A};
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/cpu_program_counter.sv
// Program counter: wrapping increment or direct load, updated on the clock edge; load wins over increment.
// No flow control; the sequencer pulses inc/load for exactly one cycle per instruction.
module cpu_program_counter #(
   parameter int PC_WIDTH = 4
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                inc,
   input  logic                load,
   input  logic [PC_WIDTH-1:0] load_val,
   output logic [PC_WIDTH-1:0] pc
);

   always_ff @(posedge clk_i) begin
      if (reset_i)
         pc <= '0;
      else if (load)
         pc <= load_val;
      else if (inc)
         pc <= pc + 1'b1;
   end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Fetch/decode/execute sequencer: 3 cycles per instruction, enables are 1-cycle pulses in EXECUTE.
// run_i gates progress only in IDLE/FETCH; HALT is left only through reset.
module cpu_control_sequencer
   import cpu_pkg::*;
#(
   parameter int PC_WIDTH   = 4,
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  run_i,
   input  logic [7:0]            instr_i,
   input  logic                  acc_zero_i,
   output logic [PC_WIDTH-1:0]   pc_o,
   output logic [DATA_WIDTH-1:0] imm_o,
   output logic [2:0]            alu_op_o,
   output logic                  acc_we_o,
   output logic                  regb_we_o,
   output logic                  out_we_o,
   output logic                  halted_o
);

   logic [2:0]             state;
   logic [2:0]             state_nxt;
   logic [INSTR_WIDTH-1:0] ir;
   logic [3:0]             opcode;
   dec_t                   dec;
   logic                   in_exec;
   logic                   jump_taken;

   assign opcode     = ir[7:4];
   assign dec        = decode_op(opcode);
   assign in_exec    = (state == ST_EXECUTE);
   assign jump_taken = (opcode == OP_JMP) || ((opcode == OP_JZ) && acc_zero_i);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (run_i) state_nxt = ST_FETCH;
         ST_FETCH:   state_nxt = run_i ? ST_DECODE : ST_IDLE;
         ST_DECODE:  state_nxt = ST_EXECUTE;
         ST_EXECUTE: state_nxt = (opcode == OP_HLT) ? ST_HALT : ST_FETCH;
         ST_HALT:    state_nxt = ST_HALT;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // alu_op_o only moves for ALU-using opcodes so its value holds across NOP/jumps
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state    <= ST_IDLE;
         ir       <= '0;
         imm_o    <= '0;
         alu_op_o <= ALU_PASS_IMM;
      end else begin
         state <= state_nxt;
         if (state == ST_FETCH && run_i)
            ir <= instr_i;
         if (state == ST_DECODE) begin
            imm_o <= DATA_WIDTH'(ir[3:0]);
            if (dec.uses_alu)
               alu_op_o <= dec.alu_op;
         end
      end
   end

   cpu_program_counter #(.PC_WIDTH(PC_WIDTH)) u_pc (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .inc      (in_exec && !jump_taken),
      .load     (in_exec && jump_taken),
      .load_val (PC_WIDTH'(ir[3:0])),
      .pc       (pc_o)
   );

   assign acc_we_o  = in_exec && dec.acc_we;
   assign regb_we_o = in_exec && dec.regb_we;
   assign out_we_o  = in_exec && dec.out_we;
   assign halted_o  = (state == ST_HALT);

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench: opcode table, directed multi-cycle sequences, then random programs vs an instruction-level model.
module tb_cpu_control_sequencer;

   logic       clk = 1'b0;
   logic       reset, run, zero;
   logic [7:0] instr;
   logic [3:0] pc, imm;
   logic [2:0] alu;
   logic       acc_we, regb_we, out_we, halted;
   logic [7:0] prog [16];

   always #5 clk = ~clk;
   assign instr = prog[pc];

   cpu_control_sequencer #(.PC_WIDTH(4), .DATA_WIDTH(4)) dut (
      .clk_i(clk), .reset_i(reset), .run_i(run), .instr_i(instr), .acc_zero_i(zero),
      .pc_o(pc), .imm_o(imm), .alu_op_o(alu), .acc_we_o(acc_we), .regb_we_o(regb_we),
      .out_we_o(out_we), .halted_o(halted)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Instruction-level reference: per-opcode effect tables plus a cycle count within the instruction.
   int   eff_we  [16] = '{0, 4, 4, 4, 4, 4, 4, 2, 1, 0, 0, 0, 0, 0, 0, 0};
   int   eff_alu [16] = '{-1, 0, 1, 2, 3, 4, 5, 6, 6, -1, -1, -1, -1, -1, -1, -1};
   int   m_pc = 0, m_step = 0, m_alu = 0, m_imm = 0;
   bit   m_halt = 0;
   logic [7:0] m_ir = '0;

   task automatic model_step();
      int op;
      if (reset) begin
         m_pc = 0; m_step = 0; m_halt = 0; m_ir = '0; m_alu = 0; m_imm = 0;
      end else if (!m_halt) begin
         op = int'(m_ir[7:4]);
         case (m_step)
            0: if (run) m_step = 1;
            1: if (!run) m_step = 0; else begin m_ir = prog[m_pc]; m_step = 2; end
            2: begin
               m_imm = int'(m_ir[3:0]);
               if (eff_alu[op] >= 0) m_alu = eff_alu[op];
               m_step = 3;
            end
            default: begin
               if (op == 15) begin
                  m_halt = 1;
                  m_pc = (m_pc + 1) % 16;
               end else begin
                  if (op == 9 || (op == 10 && zero)) m_pc = int'(m_ir[3:0]);
                  else m_pc = (m_pc + 1) % 16;
                  m_step = 1;
               end
            end
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic fill_nop();
      for (int i = 0; i < 16; i++) prog[i] = 8'h00;
   endtask

   typedef struct {
      logic [7:0] instr;
      logic       zero;
      logic [2:0] we;       // {acc, regb, out}
      logic [2:0] alu;
      logic [3:0] pc_next;
      logic       halt;
   } vec_t;

   vec_t tbl [15];

   task automatic run_one(input vec_t v, input int idx);
      string s;
      s = $sformatf("op%0h", v.instr[7:4]);
      fill_nop();
      prog[0] = v.instr;
      zero = v.zero;
      run = 1'b0;
      do_reset();
      run = 1'b1;
      tick(); tick(); tick();
      chk({s, "_we"}, {acc_we, regb_we, out_we}, v.we);
      chk({s, "_imm"}, imm, v.instr[3:0]);
      if (v.we != 3'b000) chk({s, "_alu"}, alu, v.alu);
      tick();
      chk({s, "_pc_next"}, pc, v.pc_next);
      chk({s, "_halted"}, halted, v.halt);
      if (idx < 0) $display("unreachable");
   endtask

   int exp_pc1 [7] = '{0, 0, 0, 1, 1, 1, 2};
   int regb_cnt;
   logic [2:0] exp_we;

   initial begin
      tbl[0]  = '{8'h00, 1'b0, 3'b000, 3'd0, 4'd1, 1'b0};
      tbl[1]  = '{8'h13, 1'b0, 3'b100, 3'd0, 4'd1, 1'b0};
      tbl[2]  = '{8'h22, 1'b0, 3'b100, 3'd1, 4'd1, 1'b0};
      tbl[3]  = '{8'h33, 1'b0, 3'b100, 3'd2, 4'd1, 1'b0};
      tbl[4]  = '{8'h44, 1'b0, 3'b100, 3'd3, 4'd1, 1'b0};
      tbl[5]  = '{8'h55, 1'b0, 3'b100, 3'd4, 4'd1, 1'b0};
      tbl[6]  = '{8'h66, 1'b0, 3'b100, 3'd5, 4'd1, 1'b0};
      tbl[7]  = '{8'h77, 1'b0, 3'b010, 3'd6, 4'd1, 1'b0};
      tbl[8]  = '{8'h88, 1'b0, 3'b001, 3'd6, 4'd1, 1'b0};
      tbl[9]  = '{8'h97, 1'b0, 3'b000, 3'd0, 4'd7, 1'b0};
      tbl[10] = '{8'hA7, 1'b1, 3'b000, 3'd0, 4'd7, 1'b0};
      tbl[11] = '{8'hA7, 1'b0, 3'b000, 3'd0, 4'd1, 1'b0};
      tbl[12] = '{8'hB7, 1'b1, 3'b000, 3'd0, 4'd1, 1'b0};
      tbl[13] = '{8'hE7, 1'b1, 3'b000, 3'd0, 4'd1, 1'b0};
      tbl[14] = '{8'hF0, 1'b0, 3'b000, 3'd0, 4'd1, 1'b1};

      reset = 1'b1; run = 1'b0; zero = 1'b0;
      fill_nop();
      @(negedge clk);

      // Reset values, then LDI 5 / OUT timing
      prog[0] = 8'h15; prog[1] = 8'h80;
      do_reset();
      chk("rst_pc", pc, 0);
      chk("rst_imm", imm, 0);
      chk("rst_alu", alu, 0);
      chk("rst_we", {acc_we, regb_we, out_we}, 3'b000);
      chk("rst_halted", halted, 0);
      run = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         chk($sformatf("ldi_out_pc_c%0d", c), pc, exp_pc1[c-1]);
         chk($sformatf("ldi_out_acc_c%0d", c), acc_we, (c == 3));
         chk($sformatf("ldi_out_out_c%0d", c), out_we, (c == 6));
         if (c == 3) begin chk("ldi_imm", imm, 5); chk("ldi_alu", alu, 0); end
         if (c == 6) chk("out_alu", alu, 6);
      end

      for (int i = 0; i < 15; i++) run_one(tbl[i], i);

      // JZ taken and not taken
      for (int t = 0; t < 2; t++) begin
         fill_nop();
         prog[0] = 8'h10; prog[1] = 8'hA4; prog[2] = 8'h11;
         zero = (t == 0);
         run = 1'b0;
         do_reset();
         run = 1'b1;
         for (int c = 1; c <= 7; c++) tick();
         chk($sformatf("jz_pc_zero%0d", zero), pc, (t == 0) ? 4 : 2);
      end
      zero = 1'b0;

      // All-NOP program wraps the PC with no enables
      fill_nop();
      run = 1'b0;
      do_reset();
      run = 1'b1;
      for (int c = 1; c <= 49; c++) begin
         tick();
         chk($sformatf("nop_we_c%0d", c), {acc_we, regb_we, out_we}, 3'b000);
         if (c == 46) chk("nop_pc_15", pc, 15);
         if (c == 49) chk("nop_pc_wrap", pc, 0);
      end

      // HLT at address 3: frozen, run ignored, reset recovers
      fill_nop();
      prog[3] = 8'hF0;
      run = 1'b0;
      do_reset();
      run = 1'b1;
      for (int c = 1; c <= 12; c++) tick();
      chk("hlt_halted_early", halted, 0);
      tick();
      chk("hlt_halted", halted, 1);
      chk("hlt_pc", pc, 4);
      for (int c = 0; c < 20; c++) begin
         run = ~run;
         tick();
         chk($sformatf("hlt_frozen_c%0d", c), {halted, pc, acc_we, regb_we, out_we}, {1'b1, 4'd4, 3'b000});
      end
      run = 1'b0;
      do_reset();
      chk("hlt_rst_halted", halted, 0);
      chk("hlt_rst_pc", pc, 0);
      tick();
      chk("hlt_rst_idle_pc", pc, 0);
      run = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      chk("hlt_rst_resume_pc", pc, 1);

      // Reset during EXECUTE of ADD
      fill_nop();
      prog[0] = 8'h21;
      run = 1'b0;
      do_reset();
      run = 1'b1;
      tick(); tick(); tick();
      chk("add_exec_acc", acc_we, 1);
      run = 1'b0;
      do_reset();
      chk("add_rst_all", {pc, imm, alu, acc_we, regb_we, out_we, halted}, '0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("add_rst_acc_c%0d", c), acc_we, 0);
      end

      // MOVB then run drop: one regb pulse, idle at pc 1, then resume
      fill_nop();
      prog[0] = 8'h70; prog[1] = 8'h15;
      run = 1'b0;
      do_reset();
      run = 1'b1;
      regb_cnt = 0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (regb_we === 1'b1) regb_cnt++;
         if (c == 3) run = 1'b0;
         if (c >= 4) chk($sformatf("movb_idle_pc_c%0d", c), pc, 1);
         chk($sformatf("movb_acc_c%0d", c), acc_we, 0);
      end
      chk("movb_regb_count", regb_cnt, 1);
      run = 1'b1;
      tick(); tick(); tick();
      chk("resume_acc", acc_we, 1);
      chk("resume_imm", imm, 5);
      tick();
      chk("resume_pc", pc, 2);

      // Random programs against the reference model
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
      run = 1'b0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 79) == 0);
         if (reset) for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
         run  = ($urandom_range(0, 7) != 0);
         zero = $urandom_range(0, 1);
         tick();
         exp_we = (m_step == 3 && !m_halt) ? 3'(eff_we[m_ir[7:4]]) : 3'b000;
         chk($sformatf("rnd_pc_c%0d", c), pc, m_pc);
         chk($sformatf("rnd_halted_c%0d", c), halted, m_halt);
         chk($sformatf("rnd_we_c%0d", c), {acc_we, regb_we, out_we}, exp_we);
         if (m_step == 3 && !m_halt) chk($sformatf("rnd_imm_c%0d", c), imm, m_imm);
         if (exp_we != 3'b000) chk($sformatf("rnd_alu_c%0d", c), alu, m_alu);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
